// File: rtl/demux_memoria.sv
// demux_memoria: clocked 1-to-2 demux into two FWFT FIFOs; optional DEMUX_OVF_CNT_EN adds a saturating stalled-push counter
module demux_memoria #(
   parameter int DATA_W = 2,
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] data_in,
   input  logic              valid_in,
   input  logic              selector,
   output logic              ready_in,
   input  logic              pop0,
   input  logic              pop1,
   output logic [DATA_W-1:0] data_out0,
   output logic [DATA_W-1:0] data_out1,
   output logic              valid_out0,
   output logic              valid_out1,
   output logic              full0,
   output logic              full1,
   output logic              empty0,
   output logic              empty1,
   output logic [7:0]        ovf_count
);
   localparam logic [ADDR_W:0] full_cnt = (ADDR_W+1)'(DEPTH);
   logic [DATA_W-1:0] mem [2][DEPTH];
   logic [ADDR_W-1:0] wr_ptr [2];
   logic [ADDR_W-1:0] rd_ptr [2];
   logic [ADDR_W:0]   cnt [2];
   logic [1:0]        push;
   logic [1:0]        pop;
   assign full0      = cnt[0] == full_cnt;
   assign full1      = cnt[1] == full_cnt;
   assign empty0     = cnt[0] == '0;
   assign empty1     = cnt[1] == '0;
   assign valid_out0 = !empty0;
   assign valid_out1 = !empty1;
   // ready reflects fullness before any same-cycle pop: no bypass on a full channel
   assign ready_in   = selector ? !full1 : !full0;
   assign push       = {2{valid_in & ready_in}} & {selector, !selector};
   assign pop        = {pop1 & !empty1, pop0 & !empty0};
   // memory is never reset, so stale words are masked while empty
   assign data_out0  = empty0 ? '0 : mem[0][rd_ptr[0]];
   assign data_out1  = empty1 ? '0 : mem[1][rd_ptr[1]];
   always_ff @(posedge clk)
      for (int i = 0; i < 2; i++)
         if (reset) begin
            wr_ptr[i] <= '0;
            rd_ptr[i] <= '0;
            cnt[i]    <= '0;
         end else begin
            if (push[i]) begin
               mem[i][wr_ptr[i]] <= data_in;
               wr_ptr[i]         <= wr_ptr[i] + ADDR_W'(1);
            end
            if (pop[i])
               rd_ptr[i] <= rd_ptr[i] + ADDR_W'(1);
            cnt[i] <= cnt[i] + (ADDR_W+1)'(push[i]) - (ADDR_W+1)'(pop[i]);
         end
`ifdef DEMUX_OVF_CNT_EN
   always_ff @(posedge clk)
      if (reset)
         ovf_count <= '0;
      else if (valid_in && !ready_in && ovf_count != 8'hff)
         ovf_count <= ovf_count + 8'd1;
`else
   assign ovf_count = 8'd0;
`endif
endmodule
